segment_digit: RTL and testbench

//  Seven-segment glyph renderer for the VGA score overlay. Given the current

---
 rtl/segment_digit.sv | 144 ++++++++++++++
 tb/tb_segment_digit.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/segment_digit.sv
// -----------------------------------------------------------------------------
// segment_digit
//
// Seven-segment glyph renderer for the VGA score overlay. For the current
// pixel (x, y), a digit cell origin (segx, segy) and a digit value num, it
// reports one clock later whether the pixel lies on a lit segment of the
// digit. Score blocks place one instance per decimal place and OR the isSeg
// outputs together.
//
// Parameters
//   SEG_W  digit cell width in pixels (horizontal segment length)
//   SEG_H  digit cell height in pixels; must be even
//   SEG_T  stroke thickness in pixels; SEG_T < SEG_W/2
//
// Ports
//   clk    in   1   pixel clock
//   reset  in   1   asynchronous, active-high reset
//   x      in   10  current pixel column
//   y      in   10  current pixel row
//   segx   in   10  digit cell left column
//   segy   in   10  digit cell top row
//   num    in   4   digit value, 0-9 decimal
//   isSeg  out  1   registered: pixel is on a lit segment
//
// Configuration
//   HEX_GLYPHS_EN  when defined, num 10-15 render as hexadecimal glyphs
//                  (A b C d E F); when undefined they render fully dark.
// -----------------------------------------------------------------------------
module segment_digit #(
   parameter int SEG_W = 10,
   parameter int SEG_H = 20,
   parameter int SEG_T = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [9:0] x,
   input  logic [9:0] y,
   input  logic [9:0] segx,
   input  logic [9:0] segy,
   input  logic [3:0] num,
   output logic       isSeg
);

   // Region bounds, all inclusive, expressed in the 11-bit offset domain.
   localparam int H2 = SEG_H / 2;

   localparam logic [10:0] CELL_W  = 11'(SEG_W);
   localparam logic [10:0] CELL_H  = 11'(SEG_H);
   localparam logic [10:0] T_LAST  = 11'(SEG_T - 1);
   localparam logic [10:0] D_FIRST = 11'(SEG_H - SEG_T);
   localparam logic [10:0] G_FIRST = 11'(H2 - SEG_T / 2);
   localparam logic [10:0] G_LAST  = 11'(H2 - SEG_T / 2 + SEG_T - 1);
   localparam logic [10:0] R_FIRST = 11'(SEG_W - SEG_T);
   localparam logic [10:0] HALF    = 11'(H2);

   // Segment mask bit positions, mask written as abcdefg (a is the MSB).
   localparam int SEG_A = 6;
   localparam int SEG_B = 5;
   localparam int SEG_C = 4;
   localparam int SEG_D = 3;
   localparam int SEG_E = 2;
   localparam int SEG_F = 1;
   localparam int SEG_G = 0;

   logic [10:0] dx;
   logic [10:0] dy;
   logic        in_cell;
   logic [6:0]  region;
   logic [6:0]  lit;
   logic        hit;

   // ---------------------------------------------------------------------------
   // Digit value to lit-segment mask (abcdefg).
   // ---------------------------------------------------------------------------
   function automatic logic [6:0] glyph_mask(input logic [3:0] value);
      logic [6:0] mask;
      mask = 7'b000_0000;
      case (value)
         4'd0:    mask = 7'b111_1110;
         4'd1:    mask = 7'b011_0000;
         4'd2:    mask = 7'b110_1101;
         4'd3:    mask = 7'b111_1001;
         4'd4:    mask = 7'b011_0011;
         4'd5:    mask = 7'b101_1011;
         4'd6:    mask = 7'b101_1111;
         4'd7:    mask = 7'b111_0000;
         4'd8:    mask = 7'b111_1111;
         4'd9:    mask = 7'b111_1011;
`ifdef HEX_GLYPHS_EN
         4'd10:   mask = 7'b111_0111;  // A
         4'd11:   mask = 7'b001_1111;  // b
         4'd12:   mask = 7'b100_1110;  // C
         4'd13:   mask = 7'b011_1101;  // d
         4'd14:   mask = 7'b100_1111;  // E
         4'd15:   mask = 7'b100_0111;  // F
`endif
         default: mask = 7'b000_0000;
      endcase
      return mask;
   endfunction

   // ---------------------------------------------------------------------------
   // Offsets are computed one bit wider than the coordinates so that a pixel
   // left of / above the cell shows up as a set MSB instead of wrapping into
   // a large positive offset that could land back inside the cell.
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal driven here gets a default first so no path can
      // leave it unassigned and infer a latch.
      dx      = {1'b0, x} - {1'b0, segx};
      dy      = {1'b0, y} - {1'b0, segy};
      in_cell = 1'b0;
      region  = 7'b000_0000;

      in_cell = !dx[10] && !dy[10] && (dx < CELL_W) && (dy < CELL_H);

      if (in_cell) begin
         region[SEG_A] = (dy <= T_LAST);
         region[SEG_D] = (dy >= D_FIRST);
         region[SEG_G] = (dy >= G_FIRST) && (dy <= G_LAST);
         region[SEG_F] = (dx <= T_LAST)   && (dy <  HALF);
         region[SEG_E] = (dx <= T_LAST)   && (dy >= HALF);
         region[SEG_B] = (dx >= R_FIRST)  && (dy <  HALF);
         region[SEG_C] = (dx >= R_FIRST)  && (dy >= HALF);
      end

      lit = glyph_mask(num);
      hit = |(region & lit);
   end

   // ---------------------------------------------------------------------------
   // Output register: the only flop in the block.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: state is updated with non-blocking assignments so every flop
      // samples pre-edge values regardless of process ordering.
      if (reset) begin
         isSeg <= 1'b0;
      end else begin
         isSeg <= hit;
      end
   end

endmodule

// File: tb/tb_segment_digit.sv
// -----------------------------------------------------------------------------
// tb_segment_digit
//
// Self-checking bench for segment_digit with default parameters. A table of
// pixel vectors with hand-derived expectations is applied one per clock;
// expected values are queued when the stimulus is driven and popped when the
// registered output is sampled. Reset and column-wrap sequences are written
// out by hand.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_segment_digit;

   localparam bit HEX =
`ifdef HEX_GLYPHS_EN
      1'b1;
`else
      1'b0;
`endif

   logic       clk;
   logic       reset;
   logic [9:0] x;
   logic [9:0] y;
   logic [9:0] segx;
   logic [9:0] segy;
   logic [3:0] num;
   logic       isSeg;

   int checks = 0;
   int errors = 0;

   logic  exp_q[$];
   string name_q[$];

   typedef struct {
      logic [9:0] x;
      logic [9:0] y;
      logic [9:0] sx;
      logic [9:0] sy;
      logic [3:0] num;
      logic       exp;
   } vec_t;

   vec_t vecs[$];

   segment_digit dut (
      .clk   (clk),
      .reset (reset),
      .x     (x),
      .y     (y),
      .segx  (segx),
      .segy  (segy),
      .num   (num),
      .isSeg (isSeg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic actual, input logic expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, actual, expected);
      end
   endtask

   // Drive one pixel at the falling edge, queue its expectation, and compare
   // against the output registered at the following rising edge.
   task automatic apply(input logic [9:0] px, input logic [9:0] py,
                        input logic [9:0] sx, input logic [9:0] sy,
                        input logic [3:0] n, input logic e, input string name);
      logic  got_exp;
      string got_name;
      @(negedge clk);
      x = px; y = py; segx = sx; segy = sy; num = n;
      exp_q.push_back(e);
      name_q.push_back(name);
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         check("scoreboard_empty", 1'b1, 1'b0);
      end else begin
         got_exp  = exp_q.pop_front();
         got_name = name_q.pop_front();
         check(got_name, isSeg, got_exp);
      end
   endtask

   initial begin
      // Pixel vectors around a cell at (535, 20); expectations worked out
      // from the segment geometry (W=10, H=20, T=2, g rows 9..10).
      vecs.push_back('{10'd535, 10'd20, 10'd535, 10'd20, 4'd8,  1'b1});  // a corner
      vecs.push_back('{10'd544, 10'd39, 10'd535, 10'd20, 4'd8,  1'b1});  // d/c corner
      vecs.push_back('{10'd540, 10'd29, 10'd535, 10'd20, 4'd8,  1'b1});  // g
      vecs.push_back('{10'd534, 10'd20, 10'd535, 10'd20, 4'd8,  1'b0});  // left of cell
      vecs.push_back('{10'd545, 10'd20, 10'd535, 10'd20, 4'd8,  1'b0});  // right of cell
      vecs.push_back('{10'd535, 10'd20, 10'd535, 10'd20, 4'd1,  1'b0});
      vecs.push_back('{10'd544, 10'd20, 10'd535, 10'd20, 4'd1,  1'b1});  // b
      vecs.push_back('{10'd544, 10'd35, 10'd535, 10'd20, 4'd1,  1'b1});  // c
      vecs.push_back('{10'd540, 10'd29, 10'd535, 10'd20, 4'd1,  1'b0});
      vecs.push_back('{10'd540, 10'd29, 10'd535, 10'd20, 4'd0,  1'b0});  // g dark
      vecs.push_back('{10'd540, 10'd38, 10'd535, 10'd20, 4'd0,  1'b1});  // d
      vecs.push_back('{10'd540, 10'd38, 10'd535, 10'd20, 4'd7,  1'b0});
      vecs.push_back('{10'd535, 10'd20, 10'd535, 10'd20, 4'd12, HEX});   // C
      vecs.push_back('{10'd540, 10'd29, 10'd535, 10'd20, 4'd15, HEX});   // F has g
      vecs.push_back('{10'd544, 10'd20, 10'd535, 10'd20, 4'd11, 1'b0});  // b has no b seg
      vecs.push_back('{10'd535, 10'd35, 10'd535, 10'd20, 4'd9,  1'b0});  // e dark
      vecs.push_back('{10'd544, 10'd35, 10'd535, 10'd20, 4'd2,  1'b0});  // c dark
      vecs.push_back('{10'd544, 10'd25, 10'd535, 10'd20, 4'd2,  1'b1});  // b lit
      vecs.push_back('{10'd544, 10'd25, 10'd535, 10'd20, 4'd6,  1'b0});  // b dark
      vecs.push_back('{10'd535, 10'd25, 10'd535, 10'd20, 4'd5,  1'b1});  // f lit
      vecs.push_back('{10'd535, 10'd25, 10'd535, 10'd20, 4'd3,  1'b0});  // f dark
      vecs.push_back('{10'd540, 10'd20, 10'd535, 10'd20, 4'd4,  1'b0});  // a dark
      vecs.push_back('{10'd540, 10'd29, 10'd535, 10'd20, 4'd4,  1'b1});  // g lit
      vecs.push_back('{10'd540, 10'd28, 10'd535, 10'd20, 4'd8,  1'b0});  // above g
      vecs.push_back('{10'd540, 10'd30, 10'd535, 10'd20, 4'd8,  1'b1});  // g last row
      vecs.push_back('{10'd540, 10'd31, 10'd535, 10'd20, 4'd8,  1'b0});  // below g
      vecs.push_back('{10'd535, 10'd40, 10'd535, 10'd20, 4'd8,  1'b0});  // below cell
      vecs.push_back('{10'd540, 10'd21, 10'd535, 10'd20, 4'd8,  1'b1});  // a second row
      vecs.push_back('{10'd540, 10'd22, 10'd535, 10'd20, 4'd8,  1'b0});  // past a
      vecs.push_back('{10'd536, 10'd25, 10'd535, 10'd20, 4'd8,  1'b1});  // f second col
      vecs.push_back('{10'd537, 10'd25, 10'd535, 10'd20, 4'd8,  1'b0});  // past f
      vecs.push_back('{10'd540, 10'd19, 10'd535, 10'd20, 4'd8,  1'b0});  // above cell

      // Reset state: output low before and during reset, inputs on a lit pixel.
      reset = 1'b1;
      x = 10'd535; y = 10'd20; segx = 10'd535; segy = 10'd20; num = 4'd8;
      #1;
      check("reset_initial", isSeg, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      check("reset_held", isSeg, 1'b0);
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         apply(vecs[i].x, vecs[i].y, vecs[i].sx, vecs[i].sy, vecs[i].num,
               vecs[i].exp, $sformatf("vec%0d", i));
      end

      // Reset pulse mid-stream: clears asynchronously, recovers one clock
      // after release.
      apply(10'd535, 10'd20, 10'd535, 10'd20, 4'd8, 1'b1, "pre_reset");
      #2;
      reset = 1'b1;
      #1;
      check("reset_async", isSeg, 1'b0);
      @(posedge clk);
      #1;
      check("reset_hold_edge", isSeg, 1'b0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("reset_released_no_edge", isSeg, 1'b0);
      @(posedge clk);
      #1;
      check("reset_recover", isSeg, 1'b1);

      // Cell at the right screen edge; the column counter wraps 639 -> 0.
      apply(10'd639, 10'd20, 10'd635, 10'd20, 4'd8, 1'b1, "wrap_x639");
      for (int c = 0; c <= 4; c++) begin
         apply(10'(c), 10'd20, 10'd635, 10'd20, 4'd8, 1'b0,
               $sformatf("wrap_x%0d", c));
      end

      // Far-right coordinates with a small origin must not alias into the cell.
      apply(10'd1023, 10'd20, 10'd0, 10'd20, 4'd8, 1'b0, "far_right");
      apply(10'd0, 10'd20, 10'd1020, 10'd20, 4'd8, 1'b0, "origin_right_of_x");

      check("scoreboard_drained", exp_q.size() == 0, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
